// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the streaming 1D convolution core.
// Width helpers and output saturation live here so top and MAC agree.
package conv1d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      FILL,
      RUN,
      DRAIN
   } state_t;

   localparam int SAT_W = 160;

   function automatic int acc_w(input int data_w, input int taps);
      return 2 * data_w + $clog2(taps);
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Clamp a sign-extended accumulator into a dw-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat(
      input logic signed [SAT_W-1:0] v,
      input int                      dw
   );
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = {{(SAT_W-1){1'b0}}, 1'b1};
      hi  = (one <<< (dw - 1)) - one;
      lo  = -hi - one;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Combinational TAPS-way signed multiply and sum.
// Products are full width so the sum can never overflow.
module conv1d_mac
   import conv1d_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAPS   = 3,
   parameter int ACC_W  = acc_w(DATA_W, TAPS)
) (
   input  logic [DATA_W-1:0]       window [TAPS],
   input  logic [DATA_W-1:0]       kernel [TAPS],
   output logic signed [ACC_W-1:0] acc
);

   localparam int PW = 2 * DATA_W;

   logic signed [PW-1:0] prod [TAPS];

   always_comb begin
      acc = '0;
      for (int i = 0; i < TAPS; i++) begin
         prod[i] = PW'(signed'(window[i]))
                 * PW'(signed'(kernel[i]));
         acc = acc + ACC_W'(prod[i]);
      end
   end

endmodule

// File: rtl/conv1d_stream_core.sv
// Streaming valid-mode 1D convolution: serial kernel load,
// sample window shift register, registered saturated output.
module conv1d_stream_core
   import conv1d_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int TAPS      = 3,
   parameter int SIG_LEN   = 16,
   parameter int OUT_SHIFT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              kernel_valid,
   input  logic [DATA_W-1:0] kernel_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam int ACC_W  = acc_w(DATA_W, TAPS);
   localparam int CNT_W  = cnt_w(SIG_LEN);
   localparam int KCNT_W = cnt_w(TAPS);

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0]  scnt;
   logic [CNT_W-1:0]  scnt_inc;
   logic [KCNT_W-1:0] kcnt;

   logic [DATA_W-1:0] win     [TAPS];
   logic [DATA_W-1:0] win_nxt [TAPS];
   logic [DATA_W-1:0] kern    [TAPS];

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sh;

   logic in_fire;
   logic k_last;
   logic fill_last;
   logic run_last;

   // The MAC sees the window as it will be once the new sample lands.
   always_comb begin
      for (int i = 0; i < TAPS - 1; i++) begin
         win_nxt[i] = win[i+1];
      end
      win_nxt[TAPS-1] = in_data;
   end

   conv1d_mac #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS),
      .ACC_W  (ACC_W)
   ) u_mac (
      .window (win_nxt),
      .kernel (kern),
      .acc    (acc)
   );

   assign acc_sh    = acc >>> OUT_SHIFT;
   assign scnt_inc  = scnt + 1'b1;
   assign k_last    = (kcnt == KCNT_W'(TAPS - 1));
   assign fill_last = (scnt_inc == CNT_W'(TAPS - 1));
   assign run_last  = (scnt_inc == CNT_W'(SIG_LEN));
   assign in_fire   = in_valid & in_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = LOAD_K;
         end
         LOAD_K: begin
            if (kernel_valid && k_last)
               state_nxt = (TAPS == 1) ? RUN : FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && fill_last) state_nxt = RUN;
         end
         RUN: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && run_last)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (out_valid && out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scnt      <= '0;
         kcnt      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            win[i]  <= '0;
            kern[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  scnt <= '0;
                  kcnt <= '0;
               end
            end
            LOAD_K: begin
               if (kernel_valid) begin
                  for (int i = 0; i < TAPS; i++) begin
                     if (kcnt == KCNT_W'(i)) kern[i] <= kernel_data;
                  end
                  kcnt <= kcnt + 1'b1;
               end
            end
            FILL: begin
               if (in_fire) begin
                  win  <= win_nxt;
                  scnt <= scnt_inc;
               end
            end
            RUN: begin
               if (in_fire) begin
                  win       <= win_nxt;
                  scnt      <= scnt_inc;
                  out_valid <= 1'b1;
                  out_data  <= DATA_W'(sat(
                     {{(SAT_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh},
                     DATA_W));
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv1d_stream_core.sv
// Scoreboard bench: two cores (3-tap default, 1-tap shifted),
// directed jobs push expected results, monitors pop and compare.
module tb_conv1d_stream_core;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start_a = 1'b0;
   logic          start_b = 1'b0;
   logic          kernel_valid = 1'b0;
   logic [DW-1:0] kernel_data = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b1;

   logic          in_ready_a, out_valid_a, busy_a, done_a;
   logic [DW-1:0] out_data_a;
   logic          in_ready_b, out_valid_b, busy_b, done_b;
   logic [DW-1:0] out_data_b;

   int n_cmp = 0;
   int n_bad = 0;
   int outs_a = 0, outs_b = 0;
   int dones_a = 0, dones_b = 0;
   int rdy_mode = 0;
   int cyc = 0;

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];

   always #5 clk = ~clk;

   conv1d_stream_core u_a (
      .clk          (clk),
      .reset        (reset),
      .start        (start_a),
      .kernel_valid (kernel_valid),
      .kernel_data  (kernel_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready_a),
      .in_data      (in_data),
      .out_valid    (out_valid_a),
      .out_ready    (out_ready),
      .out_data     (out_data_a),
      .busy         (busy_a),
      .done         (done_a)
   );

   conv1d_stream_core #(
      .TAPS      (1),
      .OUT_SHIFT (1)
   ) u_b (
      .clk          (clk),
      .reset        (reset),
      .start        (start_b),
      .kernel_valid (kernel_valid),
      .kernel_data  (kernel_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready_b),
      .in_data      (in_data),
      .out_valid    (out_valid_b),
      .out_ready    (out_ready),
      .out_data     (out_data_b),
      .busy         (busy_b),
      .done         (done_b)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? in_ready_b : in_ready_a;
   endfunction

   function automatic int outs_of(input bit sel);
      return sel ? outs_b : outs_a;
   endfunction

   function automatic int dones_of(input bit sel);
      return sel ? dones_b : dones_a;
   endfunction

   // out_ready pattern: always high, or high one cycle in three
   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
   end

   initial begin : mon_a
      bit            pstall = 0;
      logic [DW-1:0] pdata = '0;
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (done_a) dones_a++;
            if (out_valid_a && out_ready) begin
               if (qa.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL a_extra: got %0h expected none",
                           out_data_a);
               end else begin
                  e = qa.pop_front();
                  chk("a_out", out_data_a, e);
               end
               outs_a++;
            end
            if (pstall && out_valid_a)
               chk("a_hold", out_data_a, pdata);
            if (out_valid_a && !out_ready)
               chk("a_inrdy_stall", in_ready_a, 0);
            pstall = out_valid_a && !out_ready;
            pdata  = out_data_a;
         end else begin
            pstall = 0;
         end
      end
   end

   initial begin : mon_b
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (done_b) dones_b++;
            if (out_valid_b && out_ready) begin
               if (qb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL b_extra: got %0h expected none",
                           out_data_b);
               end else begin
                  e = qb.pop_front();
                  chk("b_out", out_data_b, e);
               end
               outs_b++;
            end
         end
      end
   end

   task automatic run_job(
      input bit            sel,
      input logic [DW-1:0] kv[$],
      input logic [DW-1:0] xv[$],
      input logic [DW-1:0] ev[$],
      input bit            gaps,
      input int            abort_after
   );
      int d0;
      int o0;
      bit ok;
      d0 = dones_of(sel);
      o0 = outs_of(sel);
      foreach (ev[i]) begin
         if (sel) qb.push_back(ev[i]);
         else     qa.push_back(ev[i]);
      end
      @(posedge clk);
      #1;
      if (sel) start_b = 1'b1;
      else     start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      foreach (kv[i]) begin
         if (gaps) begin
            kernel_valid = 1'b0;
            in_valid     = 1'b1;
            in_data      = 32'h0000_0dea;
            @(negedge clk);
            chk("ld_inrdy", rdy(sel), 0);
            @(posedge clk);
            #1;
         end
         kernel_valid = 1'b1;
         kernel_data  = kv[i];
         @(posedge clk);
         #1;
      end
      kernel_valid = 1'b0;
      in_valid     = 1'b0;
      foreach (xv[i]) begin
         if (abort_after > 0 && outs_of(sel) - o0 >= abort_after)
            break;
         if (gaps && i == 8) begin
            in_valid = 1'b0;
            if (sel) start_b = 1'b1;
            else     start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = xv[i];
         ok = 0;
         for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rdy(sel);
            @(posedge clk);
            #1;
         end
         if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_timeout: got no in_ready expected accept");
         end
      end
      in_valid = 1'b0;
      if (abort_after > 0) begin
         reset = 1'b0;
         #1;
         chk("rst_out_valid", out_valid_a, 0);
         chk("rst_out_data", out_data_a, 0);
         chk("rst_busy", busy_a, 0);
         chk("rst_in_ready", in_ready_a, 0);
         chk("rst_done", done_a, 0);
         qa.delete();
         @(posedge clk);
         #1;
         reset = 1'b1;
         return;
      end
      for (int t = 0; t < 300 && dones_of(sel) == d0; t++)
         @(negedge clk);
      repeat (3) @(negedge clk);
      chk("done_once", dones_of(sel) - d0, 1);
      chk("busy_after", sel ? busy_b : busy_a, 0);
      chk("q_empty", sel ? qb.size() : qa.size(), 0);
   endtask

   initial begin
      logic [DW-1:0] k1[$];
      logic [DW-1:0] kmax[$];
      logic [DW-1:0] k4[$];
      logic [DW-1:0] xr[$];
      logic [DW-1:0] xmax[$];
      logic [DW-1:0] xmin[$];
      logic [DW-1:0] e1[$];
      logic [DW-1:0] epos[$];
      logic [DW-1:0] eneg[$];
      logic [DW-1:0] e6[$];

      k1   = '{32'd1, 32'd2, 32'd3};
      kmax = '{32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff};
      k4   = '{32'd4};
      for (int i = 0; i < 16; i++) begin
         xr.push_back(DW'(i));
         xmax.push_back(32'h7fff_ffff);
         xmin.push_back(32'h8000_0000);
         e6.push_back(DW'(2 * i));
      end
      for (int n = 0; n < 14; n++) begin
         e1.push_back(DW'(6 * n + 8));
         epos.push_back(32'h7fff_ffff);
         eneg.push_back(32'h8000_0000);
      end

      #2;
      chk("r_in_ready", in_ready_a, 0);
      chk("r_out_valid", out_valid_a, 0);
      chk("r_out_data", out_data_a, 0);
      chk("r_busy", busy_a, 0);
      chk("r_done", done_a, 0);
      chk("r_b_out_valid", out_valid_b, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      rdy_mode = 0;
      run_job(0, k1, xr, e1, 0, 0);

      rdy_mode = 1;
      run_job(0, k1, xr, e1, 0, 0);
      rdy_mode = 0;

      run_job(0, kmax, xmax, epos, 0, 0);
      run_job(0, kmax, xmin, eneg, 0, 0);

      run_job(0, k1, xr, e1, 1, 0);

      run_job(0, k1, xr, e1, 0, 5);
      run_job(0, k1, xr, e1, 0, 0);

      run_job(1, k4, xr, e6, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule
